// File: rtl/multicycle_alu.sv
// multicycle_alu: valid/ready ALU with single-cycle logic/arithmetic ops and an iterative multiply/divide unit.
// Define MULTICYCLE_ALU_MULDIV_EN to build ops 11-14 (MUL/MULHU/DIVU/REMU); otherwise they decode as illegal.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             neg,
    output logic             div_zero,
    output logic             illegal_op
);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic             dz_q, dz_d, ill_q, ill_d;
    logic [WIDTH-1:0] sc_res_s, sc_sum_s, sc_diff_s;
    logic             sc_ovf_s, sc_ill_s;

`ifdef MULTICYCLE_ALU_MULDIV_EN
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, work_q, work_d, opnd_q, opnd_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;
    logic [WIDTH-1:0] step_acc_s, step_work_s, fin_s;
    logic             is_muldiv_s, is_div_s;

    // mul: {acc,work} is the product register with the multiplier in work; div: acc = remainder, work = dividend/quotient
    assign mul_sum_s   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_sh_s    = {acc_q, work_q[WIDTH-1]};
    assign div_diff_s  = div_sh_s - {1'b0, opnd_q};
    assign is_muldiv_s = (op >= OP_MUL) && (op <= OP_REMU);
    assign is_div_s    = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign fin_s       = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? step_acc_s : step_work_s;

    // One shift-add or restoring-divide step; a zero divisor naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        step_acc_s  = acc_q;
        step_work_s = work_q;
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            step_acc_s  = mul_sum_s[WIDTH:1];
            step_work_s = {mul_sum_s[0], work_q[WIDTH-1:1]};
        end else if (!div_diff_s[WIDTH]) begin
            step_acc_s  = div_diff_s[WIDTH-1:0];
            step_work_s = {work_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc_s  = div_sh_s[WIDTH-1:0];
            step_work_s = {work_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Single-cycle operation results computed straight from the request inputs
    always_comb begin
        sc_sum_s  = port_a + port_b;
        sc_diff_s = port_a - port_b;
        sc_res_s  = {WIDTH{1'b0}};
        sc_ovf_s  = 1'b0;
        sc_ill_s  = 1'b0;
        case (op)
            OP_SLL:  sc_res_s = port_b << port_a[SHW-1:0];
            OP_SRL:  sc_res_s = port_b >> port_a[SHW-1:0];
            OP_SRA:  sc_res_s = $unsigned($signed(port_b) >>> port_a[SHW-1:0]);
            OP_ADD: begin
                sc_res_s = sc_sum_s;
                sc_ovf_s = (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sc_sum_s[WIDTH-1] != port_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = sc_diff_s;
                sc_ovf_s = (port_a[WIDTH-1] != port_b[WIDTH-1]) && (sc_diff_s[WIDTH-1] != port_a[WIDTH-1]);
            end
            OP_AND:  sc_res_s = port_a & port_b;
            OP_OR:   sc_res_s = port_a | port_b;
            OP_XOR:  sc_res_s = port_a ^ port_b;
            OP_NOR:  sc_res_s = ~(port_a | port_b);
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
            OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (port_a < port_b)};
            default: sc_ill_s = 1'b1;
        endcase
    end

    // Next-state and datapath register updates for the IDLE/BUSY/DONE controller
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
`ifdef MULTICYCLE_ALU_MULDIV_EN
        op_d    = op_q;
        acc_d   = acc_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
                    if (is_muldiv_s) begin
                        state_d = BUSY;
                        op_d    = op;
                        cnt_d   = SHW'(WIDTH - 1);
                        acc_d   = {WIDTH{1'b0}};
                        work_d  = (op >= OP_DIVU) ? port_a : port_b;
                        opnd_d  = (op >= OP_DIVU) ? port_b : port_a;
                    end else
`endif
                    begin
                        state_d = DONE;
                        res_d   = sc_res_s;
                        ovf_d   = sc_ovf_s;
                        zero_d  = (sc_res_s == {WIDTH{1'b0}});
                        neg_d   = sc_res_s[WIDTH-1];
                        dz_d    = 1'b0;
                        ill_d   = sc_ill_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
`ifdef MULTICYCLE_ALU_MULDIV_EN
                acc_d  = step_acc_s;
                work_d = step_work_s;
                if (cnt_q == {SHW{1'b0}}) begin
                    state_d = DONE;
                    res_d   = fin_s;
                    ovf_d   = 1'b0;
                    zero_d  = (fin_s == {WIDTH{1'b0}});
                    neg_d   = fin_s[WIDTH-1];
                    dz_d    = is_div_s && (opnd_q == {WIDTH{1'b0}});
                    ill_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            res_q   <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            op_q    <= 4'd0;
            acc_q   <= {WIDTH{1'b0}};
            work_q  <= {WIDTH{1'b0}};
            opnd_q  <= {WIDTH{1'b0}};
            cnt_q   <= {SHW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            op_q    <= op_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign result     = res_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;
    assign neg        = neg_q;
    assign div_zero   = dz_q;
    assign illegal_op = ill_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from port_a[SHW-1:0].
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  request present on op/port_a/port_b.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  4  operation: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 MUL, 12 MULHU, 13 DIVU, 14 REMU, 15 reserved.
REQ-008 port_a  input  WIDTH  operand A; shift amount for shifts.
REQ-009 port_b  input  WIDTH  operand B; shifted value for shifts.
REQ-010 resp_valid  output  1  result/flags valid.
REQ-011 resp_ready  input  1  consumer takes the response this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 overflow, zero, neg, div_zero, illegal_op  output  1 each  registered status flags.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; req_ready = 1 only in IDLE.
REQ-015 Handshake: request accepted when req_valid && req_ready; operands and op latched on acceptance; inputs ignored otherwise.
REQ-016 Single-cycle ops (0-10, 15): IDLE -> DONE on acceptance; resp_valid asserted the next cycle (latency 1).
REQ-017 Multi-cycle ops (11-14): IDLE -> BUSY; iteration counter loads WIDTH-1 and decrements once per cycle; BUSY -> DONE when counter = 0; resp_valid asserted exactly WIDTH+1 cycles after acceptance.
REQ-018 DONE holds result and flags stable until resp_valid && resp_ready, then -> IDLE; no new request is accepted in the same cycle.
REQ-019 Shifts use port_a[SHW-1:0] only; SRA fills with port_b[WIDTH-1].
REQ-020 ADD/SUB two's-complement modulo 2^WIDTH; overflow = signed overflow (ADD: equal operand signs, result sign differs; SUB: operand signs differ, result sign differs from A); overflow = 0 for all other ops.
REQ-021 SLT signed, SLTU unsigned compare; result 1 or 0 zero-extended.
REQ-022 MUL returns low WIDTH bits, MULHU high WIDTH bits of the unsigned 2*WIDTH product; iterative shift-add, one bit per cycle.
REQ-023 DIVU/REMU unsigned restoring division, one quotient bit per cycle.
REQ-024 Divide by zero: still takes WIDTH+1 cycles; DIVU result all ones, REMU result = port_a, div_zero = 1; div_zero = 0 otherwise.
REQ-025 zero = (result == 0); neg = result[WIDTH-1]; both computed from the final result and valid with resp_valid.
REQ-026 op 15: result 0, illegal_op = 1, zero = 1, latency 1.
REQ-027 Outputs other than req_ready/resp_valid are don't-care to consumers but SHALL NOT change while in DONE.

Reset
REQ-028 RST asserted at any time, including mid-BUSY or in DONE, forces IDLE immediately, aborts the operation, and discards its response.
REQ-029 Reset values: req_ready = 1 (after RST deasserts), resp_valid = 0, result = 0, all flags 0, iteration counter = 0.

Configuration
REQ-030 Macro MULTICYCLE_ALU_MULDIV_EN defined: ops 11-14 behave per REQ-017..REQ-024.
REQ-031 Macro undefined: no multiply/divide hardware; ops 11-14 behave as op 15 (REQ-026), latency 1, and BUSY is never entered.

Verification (WIDTH = 32, macro defined unless stated)
REQ-032 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow = 1, neg = 1, resp_valid 1 cycle after accept.
REQ-033 SRA port_a = 4, port_b = 0xF0000000 -> result 0xFF000000; SLL port_a = 33 -> shifts by 1.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE, resp_valid exactly 33 cycles after accept; MUL of the same operands -> 0x00000001.
REQ-035 DIVU 100 / 0 -> result 0xFFFFFFFF, div_zero = 1; REMU 100 / 7 -> result 2, zero = 0.
REQ-036 Hold resp_ready = 0 for 5 cycles in DONE -> result and flags stable, req_ready = 0, new req_valid ignored; then resp_ready = 1 -> IDLE next cycle.
REQ-037 Assert RST 10 cycles into a DIVU -> resp_valid = 0 immediately and no stale response after release; macro undefined: MUL 3 x 4 -> illegal_op = 1, result 0, latency 1.
